// File: rtl/text_buffer.sv
// text_buffer: COLS x ROWS grid of 8-bit glyph codes with a byte-stream write port, cursor and 1-cycle read port.
// Optional feature macro CURSOR_BLINK_EN adds frame_tick and overlays CURSOR_CODE on the cursor cell.
module text_buffer #(
  parameter int         COLS        = 40,
  parameter int         ROWS        = 15,
  parameter logic [7:0] BLANK_CODE  = 8'd0,
  parameter logic [7:0] CURSOR_CODE = 8'd127
) (
  input  logic       VGA_clk,
  input  logic       reset_n,
`ifdef CURSOR_BLINK_EN
  input  logic       frame_tick,
`endif
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic [5:0] rd_col,
  input  logic [3:0] rd_row,
  output logic [7:0] rd_char,
  output logic [5:0] cursor_col,
  output logic [3:0] cursor_row,
  output logic       busy
);

  localparam int            DEPTH     = COLS * ROWS;
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [5:0]    LAST_COL  = 6'(COLS - 1);
  localparam logic [3:0]    LAST_ROW  = 4'(ROWS - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [5:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic [7:0]    rd_char_q, rd_char_d;
  logic [7:0]    mem_q [DEPTH];

  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_in_range;
  logic          blink_hit;

  // Write handshake: a byte transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready is a pure function of state (high only in IDLE), never of wr_valid.
  assign wr_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_CLEAR);
  assign accept     = wr_valid && wr_ready;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign rd_char    = rd_char_q;

  assign cur_addr    = AW'(row_q) * COLS_A + AW'(col_q);
  assign rd_addr     = AW'(rd_row) * COLS_A + AW'(rd_col);
  assign rd_in_range = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    col_d      = col_q;
    row_d      = row_q;
    mem_we     = 1'b0;
    mem_waddr  = cur_addr;
    mem_wdata  = wr_char;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = BLANK_CODE;
        if (clr_addr_q == LAST_ADDR) state_d = ST_IDLE;
        else                         clr_addr_d = clr_addr_q + 1'b1;
      end
      ST_IDLE: begin
        if (accept) begin
          case (wr_char)
            8'h0C: begin
              col_d      = '0;
              row_d      = '0;
              clr_addr_d = '0;
              state_d    = ST_CLEAR;
            end
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d = '0;
              row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end
            default: begin
              mem_we = 1'b1;
              if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

`ifdef CURSOR_BLINK_EN
  logic [4:0] frame_cnt_q;

  always_ff @(posedge VGA_clk) begin
    if (!reset_n)        frame_cnt_q <= '0;
    else if (frame_tick) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  // Overlay uses the address presented this edge, so it keeps the normal 1-cycle latency.
  assign blink_hit = frame_cnt_q[4] && (state_q == ST_IDLE) &&
                     (rd_col == col_q) && (rd_row == row_q);
`else
  assign blink_hit = 1'b0;
`endif

  always_comb begin
    rd_char_d = BLANK_CODE;
    if (blink_hit)        rd_char_d = CURSOR_CODE;
    else if (rd_in_range) rd_char_d = mem_q[rd_addr];
  end

  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rd_char_q  <= BLANK_CODE;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rd_char_q  <= rd_char_d;
    end
  end

  // Non-blocking write gives read-before-write on a same-address collision.
  always_ff @(posedge VGA_clk) begin
    if (reset_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: reference grid model, read scoreboard with an expected queue, directed plus random stimulus.
module tb_text_buffer;

  localparam int COLS = 40;
  localparam int ROWS = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_char = 8'd0;
  logic       wr_ready;
  logic [5:0] rd_col = 6'd0;
  logic [3:0] rd_row = 4'd0;
  logic [7:0] rd_char;
  logic [5:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;
`ifdef CURSOR_BLINK_EN
  logic       frame_tick = 1'b0;
`endif

  text_buffer dut (
    .VGA_clk    (clk),
    .reset_n    (reset_n),
`ifdef CURSOR_BLINK_EN
    .frame_tick (frame_tick),
`endif
    .wr_valid   (wr_valid),
    .wr_char    (wr_char),
    .wr_ready   (wr_ready),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] model_mem [ROWS][COLS];
  int cx, cy, fc;

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model_mem[r][c] = 8'd0;
    cx = 0;
    cy = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b == 8'h0C) begin
      model_clear();
    end else if (b == 8'h0D) begin
      cx = 0;
    end else if (b == 8'h0A) begin
      cx = 0;
      cy = (cy + 1) % ROWS;
    end else begin
      model_mem[cy][cx] = b;
      cx = cx + 1;
      if (cx == COLS) begin
        cx = 0;
        cy = (cy + 1) % ROWS;
      end
    end
  endtask

  function automatic logic [7:0] model_read(input int c, input int r);
`ifdef CURSOR_BLINK_EN
    if (((fc % 32) >= 16) && c == cx && r == cy) return 8'd127;
`endif
    if (c >= COLS || r >= ROWS) return 8'd0;
    return model_mem[r][c];
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       rd_req = 1'b0;
  logic       rd_req_d = 1'b0;
  logic [7:0] mon_exp;

  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (rd_req_d) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_char: got %0d with no expected value queued", rd_char);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_char !== mon_exp) begin
          n_err++;
          $display("FAIL rd_char: got %0d expected %0d at t=%0t", rd_char, mon_exp, $time);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int c, input int r);
    rd_col = 6'(c);
    rd_row = 4'(r);
    exp_q.push_back(model_read(c, r));
    rd_req = 1'b1;
    cycle();
    rd_req = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_char  = b;
    model_apply(b);
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic goto_cell(input int c, input int r);
    write_byte(8'h0D);
    while (cy != r) write_byte(8'h0A);
    repeat (c) write_byte(8'($urandom_range(32, 126)));
  endtask

  task automatic measure_busy(output int n, output int first_rdy);
    n = 0;
    first_rdy = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 0) first_rdy = int'(wr_ready);
      if (!busy) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cursor(input string name);
    check({name, "_col"}, int'(cursor_col), cx);
    check({name, "_row"}, int'(cursor_row), cy);
  endtask

`ifdef CURSOR_BLINK_EN
  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      fc++;
      cycle();
      frame_tick = 1'b0;
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int n, r0, c, r, k;
    logic [7:0] b;
    logic do_wr;

    model_clear();
    fc = 0;

    reset_n = 1'b0;
    repeat (2) cycle();
    check("rst_busy", int'(busy), 1);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_rd_char", int'(rd_char), 0);
    check("rst_cursor_col", int'(cursor_col), 0);
    check("rst_cursor_row", int'(cursor_row), 0);
    cycle();
    reset_n = 1'b1;
    measure_busy(n, r0);
    check("init_clear_cycles", n, 600);
    check("init_clear_ready_low", r0, 0);
    check("init_ready_after", int'(wr_ready), 1);
    read_cell(0, 0);
    read_cell(39, 14);

    write_byte(8'd38);
    write_byte(8'd74);
    check_cursor("two_bytes");
    read_cell(0, 0);
    read_cell(1, 0);

    goto_cell(39, 3);
    write_byte(8'd59);
    check_cursor("wrap_col");
    read_cell(39, 3);
    read_cell(0, 4);
    goto_cell(39, 14);
    write_byte(8'd59);
    check_cursor("wrap_corner");
    read_cell(39, 14);

    goto_cell(12, 14);
    write_byte(8'h0A);
    check_cursor("lf_wrap");
    read_cell(12, 14);
    goto_cell(5, 2);
    write_byte(8'h0D);
    check_cursor("cr");
    read_cell(4, 2);

    read_cell(40, 0);
    read_cell(0, 15);
    read_cell(63, 15);

    // random mixed writes and reads, often hitting the cursor cell in the write cycle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        c = cx;
        r = cy;
      end else begin
        c = $urandom_range(0, 47);
        r = $urandom_range(0, 15);
      end
      k = $urandom_range(0, 19);
      b = (k == 0) ? 8'h0A : (k == 1) ? 8'h0D : 8'($urandom_range(1, 255));
      if (b == 8'h0C) b = 8'h41;
      do_wr = ($urandom_range(0, 3) != 0);
      rd_col = 6'(c);
      rd_row = 4'(r);
      exp_q.push_back(model_read(c, r));
      rd_req = 1'b1;
      if (do_wr) begin
        wr_valid = 1'b1;
        wr_char  = b;
        model_apply(b);
      end
      cycle();
      rd_req   = 1'b0;
      wr_valid = 1'b0;
      if (i % 100 == 99) check_cursor("random");
    end

    write_byte(8'h0C);
    measure_busy(n, r0);
    check("ff_clear_cycles", n, 600);
    check("ff_ready_low_next", r0, 0);
    check_cursor("ff");
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        read_cell(cc, rr);

    goto_cell(7, 6);
    write_byte(8'h0C);
    repeat (300) cycle();
    check("mid_clear_busy", int'(busy), 1);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    model_clear();
    fc = 0;
    measure_busy(n, r0);
    check("restart_clear_cycles", n, 600);
    check_cursor("restart");
    read_cell(7, 6);
    read_cell(39, 14);

`ifdef CURSOR_BLINK_EN
    write_byte(8'd88);
    write_byte(8'd89);
    write_byte(8'h0D);
    tick(15);
    read_cell(0, 0);
    tick(1);
    read_cell(0, 0);
    read_cell(1, 0);
    tick(16);
    read_cell(0, 0);
`endif

    cycle();
    cycle();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
